// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment capture block: segment code table,
// FSM and anode-action encodings, default timing constants and anode helpers.
package sevseg_pkg;

  localparam logic [15:0] SETTLE_CYCLES_DEF = 16'd8;
  localparam logic [19:0] FRAME_TIMEOUT_DEF = 20'h40000;

  // Active-low cathode patterns {ca..cg}; entry k shows hex digit k.
  localparam logic [15:0][6:0] SEG_CODES = {
    7'b0111000, // F
    7'b0010000, // E
    7'b1000010, // d
    7'b0110001, // C
    7'b1100000, // b
    7'b0001000, // A
    7'b0000100, // 9
    7'b0000000, // 8
    7'b0001111, // 7
    7'b0100000, // 6
    7'b0100100, // 5
    7'b1001100, // 4
    7'b0000110, // 3
    7'b0010010, // 2
    7'b1001111, // 1
    7'b0000001  // 0
  };

  localparam logic [6:0] BLANK_CODE = 7'b1111111;

  typedef enum logic [1:0] {HUNT, SETTLE, HOLD} state_t;

  typedef enum logic [1:0] {ACT_STAY, ACT_ADVANCE, ACT_EMIT, ACT_ABORT} act_t;

  // Index of the lowest asserted (low) anode; only meaningful when exactly one is low.
  function automatic logic [1:0] anode_index(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (!an[k]) idx = 2'(k);
    end
    return idx;
  endfunction

  function automatic logic multi_low(input logic [3:0] an);
    logic [3:0] low;
    low = ~an;
    return (low & (low - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/sevseg_capture_if.sv
// Capture result bus. SEVSEG_CAPTURE_DP_EN adds the per-digit decimal-point field.
interface sevseg_capture_if;
  // o_valid is a one-cycle strobe with no backpressure: o_data/o_blank_mask/o_err
  // are meaningful only while o_valid is high; o_err high with o_valid low marks an abort.
  logic [15:0] o_data;
  logic [3:0]  o_blank_mask;
  logic        o_valid;
  logic        o_err;
`ifdef SEVSEG_CAPTURE_DP_EN
  logic [3:0]  o_dp;

  modport master (output o_data, o_blank_mask, o_valid, o_err, o_dp);
  modport slave  (input  o_data, o_blank_mask, o_valid, o_err, o_dp);
`else
  modport master (output o_data, o_blank_mask, o_valid, o_err);
  modport slave  (input  o_data, o_blank_mask, o_valid, o_err);
`endif
endinterface

// File: rtl/sevseg_pattern_decode.sv
// Combinational seven-segment pattern to hex nibble decoder; unknown patterns flag invalid.
module sevseg_pattern_decode
  import sevseg_pkg::*;
(
  input  logic [6:0] i_code,
  output logic [3:0] o_nibble,
  output logic       o_valid
);

  always_comb begin
    o_nibble = 4'd0;
    o_valid  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (i_code == SEG_CODES[k]) begin
        o_nibble = 4'(k);
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sevseg_capture.sv
// Recovers a 4-digit hex value from a multiplexed seven-segment display drive.
// Define SEVSEG_CAPTURE_DP_EN to also capture the per-digit decimal points.
module sevseg_capture
  import sevseg_pkg::*;
#(
  parameter logic [15:0] SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter logic [19:0] FRAME_TIMEOUT = FRAME_TIMEOUT_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [3:0]       an,
  input  logic             ca,
  input  logic             cb,
  input  logic             cc,
  input  logic             cd,
  input  logic             ce,
  input  logic             cf,
  input  logic             cg,
  input  logic             dp,
  sevseg_capture_if.master o_cap,
  output state_t           o_dbg_state
);

  logic [11:0] r_sync1, r_sync2, r_prev;
  state_t      r_state;
  logic [1:0]  r_idx;
  logic [15:0] r_cnt;
  logic [19:0] r_to_cnt;
  logic [15:0] r_buf;
  logic [3:0]  r_blank;
  logic        r_ferr;
`ifdef SEVSEG_CAPTURE_DP_EN
  logic [3:0]  r_dpbuf;
`endif

  logic [3:0]  w_an;
  logic [6:0]  w_seg;
  logic        w_none, w_multi, w_change, w_to_hit, w_code_ok;
  logic [1:0]  w_j;
  logic [3:0]  w_nib;
  act_t        w_act;

  // Sync vector layout: {an[3:0], ca..cg, dp}.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= {an, ca, cb, cc, cd, ce, cf, cg, dp};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_an     = r_sync2[11:8];
  assign w_seg    = r_sync2[7:1];
  assign w_none   = (w_an == 4'hF);
  assign w_multi  = multi_low(w_an);
  assign w_j      = anode_index(w_an);
  assign w_change = (r_sync2 != r_prev);
  assign w_to_hit = w_none && (r_to_cnt == FRAME_TIMEOUT - 20'd1);

  sevseg_pattern_decode u_decode (
    .i_code   (w_seg),
    .o_nibble (w_nib),
    .o_valid  (w_code_ok)
  );

  // What the currently driven anode means relative to the slot being captured.
  always_comb begin
    w_act = ACT_STAY;
    if (w_none)             w_act = ACT_STAY;
    else if (w_multi)       w_act = ACT_ABORT;
    else if (w_j == r_idx)  w_act = ACT_STAY;
    else if (w_j > r_idx)   w_act = ACT_ADVANCE;
    else if (w_j == 2'd0)   w_act = ACT_EMIT;
    else                    w_act = ACT_ABORT;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state            <= HUNT;
      r_idx              <= 2'd0;
      r_cnt              <= '0;
      r_to_cnt           <= '0;
      r_buf              <= '0;
      r_blank            <= '0;
      r_ferr             <= 1'b0;
      o_cap.o_data       <= '0;
      o_cap.o_blank_mask <= '0;
      o_cap.o_valid      <= 1'b0;
      o_cap.o_err        <= 1'b0;
`ifdef SEVSEG_CAPTURE_DP_EN
      r_dpbuf            <= '0;
      o_cap.o_dp         <= '0;
`endif
    end else begin
      o_cap.o_valid <= 1'b0;
      o_cap.o_err   <= 1'b0;

      if (!w_none || w_to_hit) r_to_cnt <= '0;
      else                     r_to_cnt <= r_to_cnt + 20'd1;

      // Timeout only fires with all anodes high, so it never collides with an anode event.
      if (w_to_hit) begin
        o_cap.o_data       <= '0;
        o_cap.o_blank_mask <= 4'hF;
        o_cap.o_valid      <= 1'b1;
`ifdef SEVSEG_CAPTURE_DP_EN
        o_cap.o_dp         <= '0;
`endif
        r_state            <= HUNT;
      end else begin
        case (r_state)
          HUNT: begin
            if (w_an == 4'b1110) begin
              r_idx   <= 2'd0;
              r_cnt   <= '0;
              r_buf   <= '0;
              r_blank <= 4'hF;
              r_ferr  <= 1'b0;
`ifdef SEVSEG_CAPTURE_DP_EN
              r_dpbuf <= '0;
`endif
              r_state <= SETTLE;
            end
          end
          SETTLE, HOLD: begin
            case (w_act)
              ACT_ABORT: begin
                o_cap.o_err <= 1'b1;
                r_state     <= HUNT;
              end
              ACT_EMIT: begin
                // Slots never latched in this frame still hold nibble 0 and blank=1.
                o_cap.o_data       <= r_buf;
                o_cap.o_blank_mask <= r_blank;
                o_cap.o_err        <= r_ferr;
                o_cap.o_valid      <= 1'b1;
`ifdef SEVSEG_CAPTURE_DP_EN
                o_cap.o_dp         <= r_dpbuf;
                r_dpbuf            <= '0;
`endif
                r_buf   <= '0;
                r_blank <= 4'hF;
                r_ferr  <= 1'b0;
                r_idx   <= 2'd0;
                r_cnt   <= '0;
                r_state <= SETTLE;
              end
              ACT_ADVANCE: begin
                r_idx   <= w_j;
                r_cnt   <= '0;
                r_state <= SETTLE;
              end
              default: begin
                if (r_state == SETTLE) begin
                  if (w_change || w_none) begin
                    r_cnt <= '0;
                  end else if (r_cnt >= SETTLE_CYCLES - 16'd1) begin
                    r_buf[{r_idx, 2'b00} +: 4] <= w_code_ok ? w_nib : 4'd0;
                    r_blank[r_idx]             <= 1'b0;
                    if (!w_code_ok) r_ferr <= 1'b1;
`ifdef SEVSEG_CAPTURE_DP_EN
                    r_dpbuf[r_idx]             <= ~r_sync2[0];
`endif
                    r_state <= HOLD;
                  end else begin
                    r_cnt <= r_cnt + 16'd1;
                  end
                end
              end
            endcase
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sevseg_capture.sv
// Directed bench for sevseg_capture: scans digit patterns onto the pins and scores
// every o_valid/o_err pulse against an expected queue filled as stimulus is driven.
module tb_sevseg_capture;
  import sevseg_pkg::*;

  localparam int FT = 1000;
  localparam int W  = 23; // {lat_check, valid, err, blank[3:0], data[15:0]}

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic [3:0] an  = 4'hF;
  logic [6:0] seg = 7'h7F;
  logic       dp  = 1'b1;
  state_t     dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int an0_fall_cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [6:0]   seg_tab [16];

  sevseg_capture_if cap();

  sevseg_capture #(.SETTLE_CYCLES(16'd8), .FRAME_TIMEOUT(20'(FT))) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .an          (an),
    .ca          (seg[6]),
    .cb          (seg[5]),
    .cc          (seg[4]),
    .cd          (seg[3]),
    .ce          (seg[2]),
    .cf          (seg[1]),
    .cg          (seg[0]),
    .dp          (dp),
    .o_cap       (cap),
    .o_dbg_state (dbg_state)
  );

  // Clock and cycle counter
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Scoreboard: every output pulse must match the head of the expected queue
  always @(negedge sys_clk) begin
    if (!sys_rst && (cap.o_valid === 1'b1 || cap.o_err === 1'b1)) begin
      n_tests++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_pulse observed v=%0b e=%0b data=%h, expected no pulse",
               cap.o_valid, cap.o_err, cap.o_data);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        n_tests++;
        assert ({cap.o_valid, cap.o_err, cap.o_blank_mask, cap.o_data} === mon_e[21:0]) else begin
          n_fail++;
          $error("FAIL pulse_fields observed v=%0b e=%0b mask=%b data=%h expected v=%0b e=%0b mask=%b data=%h",
                 cap.o_valid, cap.o_err, cap.o_blank_mask, cap.o_data,
                 mon_e[21], mon_e[20], mon_e[19:16], mon_e[15:0]);
        end
        if (mon_e[22]) begin
          n_tests++;
          assert ((cyc - an0_fall_cyc) <= 4) else begin
            n_fail++;
            $error("FAIL emit_latency observed %0d cycles expected <= 4", cyc - an0_fall_cyc);
          end
        end
      end
    end
  end

  function automatic logic [W-1:0] mk(input logic lat, input logic v, input logic e,
                                      input logic [3:0] blank, input logic [15:0] data);
    return {lat, v, e, blank, data};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver tasks: all of them start and end on a falling clock edge
  task automatic show(input logic [3:0] a, input logic [6:0] s, input int dwell);
    if (a == 4'b1110 && an != 4'b1110) an0_fall_cyc = cyc;
    an  = a;
    seg = s;
    dp  = 1'b1;
    repeat (dwell) @(negedge sys_clk);
  endtask

  task automatic scan(input logic [15:0] v, input logic [3:0] lit, input int dwell);
    logic [3:0] sel;
    for (int k = 0; k < 4; k++) begin
      if (lit[k]) begin
        sel = 4'b0001 << k;
        show(~sel, seg_tab[v[4*k +: 4]], dwell + int'($urandom_range(0, 20)));
      end
    end
  endtask

  task automatic close_frame(input logic [3:0] first_nib, input logic [W-1:0] e, input int dwell);
    exp_q.push_back(e);
    show(4'b1110, seg_tab[first_nib], dwell);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset(input string tag);
    @(negedge sys_clk);
    an = 4'hF; seg = 7'h7F; dp = 1'b1;
    sys_rst = 1'b1;
    #1;
    check({tag, "_outs"}, {10'd0, cap.o_valid, cap.o_err, cap.o_blank_mask, cap.o_data}, 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'(HUNT));
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  initial begin
    int n;
    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010;
    seg_tab[3]  = 7'b0000110; seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0000100; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
    seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010; seg_tab[14] = 7'b0010000;
    seg_tab[15] = 7'b0111000;

    do_reset("reset_initial");

    // Full frame 1A3F with long dwell, emitted at the next an[0]
    scan(16'h1A3F, 4'hF, 200);
    close_frame(4'hF, mk(1'b1, 1'b1, 1'b0, 4'b0000, 16'h1A3F), 200);
    drain("scan_1a3f", 20);

    // Two-digit frame, upper anodes never driven
    do_reset("reset_two_digit");
    scan(16'h0042, 4'b0011, 40);
    close_frame(4'h2, mk(1'b1, 1'b1, 1'b0, 4'b1100, 16'h0042), 40);
    drain("two_digit", 20);

    // All anodes idle: timeout frames at a fixed period
    do_reset("reset_timeout");
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 16'h0000));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 16'h0000));
    n = 0;
    while (cap.o_valid !== 1'b1 && n < 3 * FT) begin
      @(negedge sys_clk);
      n++;
    end
    check("timeout_first", 32'((n >= FT) && (n <= FT + 4)), 32'd1);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (cap.o_valid !== 1'b1 && n < 3 * FT);
    check("timeout_period", n, FT);
    drain("timeout", 5);

    // Two anodes low mid-frame: abort, then only a complete new frame emits
    do_reset("reset_abort");
    scan(16'h1234, 4'hF, 40);
    close_frame(4'h4, mk(1'b1, 1'b1, 1'b0, 4'b0000, 16'h1234), 40);
    show(4'b1101, seg_tab[3], 20);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 16'h1234));
    show(4'b1100, seg_tab[3], 40);
    drain("abort_multi", 5);
    show(4'b1101, seg_tab[14], 40);
    scan(16'hBEEF, 4'hF, 40);
    close_frame(4'hF, mk(1'b1, 1'b1, 1'b0, 4'b0000, 16'hBEEF), 40);
    drain("after_abort", 20);

    // Invalid pattern on digit 1, then an out-of-order anode sequence
    do_reset("reset_invalid");
    show(4'b1110, seg_tab[7], 40);
    show(4'b1101, 7'b1111110, 40);
    show(4'b1011, seg_tab[12], 40);
    show(4'b0111, seg_tab[13], 40);
    close_frame(4'h7, mk(1'b1, 1'b1, 1'b1, 4'b0000, 16'hDC07), 40);
    show(4'b1011, seg_tab[1], 40);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0000, 16'hDC07));
    show(4'b1101, seg_tab[2], 40);
    drain("invalid_then_abort", 5);
    scan(16'h5678, 4'hF, 40);
    close_frame(4'h8, mk(1'b1, 1'b1, 1'b0, 4'b0000, 16'h5678), 40);
    drain("err_flag_cleared", 20);

    // Reset while digit 2 is settling
    show(4'b1101, seg_tab[7], 40);
    show(4'b1011, seg_tab[6], 4);
    check("state_settle", 32'(dbg_state), 32'(SETTLE));
    do_reset("reset_mid_settle");
    scan(16'h9ABC, 4'hF, 40);
    close_frame(4'hC, mk(1'b1, 1'b1, 1'b0, 4'b0000, 16'h9ABC), 40);
    drain("after_reset", 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
